// File: rtl/sonic_inv_key_schedule_128x256.sv
// Inverse key schedule: runs n_steps backward steps of the 128x256 schedule.
// Each step is 7 LIN cycles that solve for L from Y, then one FIN cycle that rebuilds H.
module sonic_inv_key_schedule_128x256 (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] key_in,
  input  logic [5:0]   n_steps,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] key_out
);

  typedef enum logic [1:0] {IDLE, LIN, FIN, DONE} state_t;

  state_t       state, state_nx;
  logic [255:0] work, work_nx;
  logic [127:0] v, v_nx;
  logic [2:0]   iter, iter_nx;
  logic [5:0]   steps, steps_nx;

  logic [127:0] v_step;
  logic [127:0] t;
  logic [127:0] l;
  logic [127:0] h;

  function automatic logic [127:0] rotl(input logic [127:0] x, input int unsigned k);
    logic [255:0] d;
    d = {x, x} << k;
    return d[255:128];
  endfunction

  // Repeated squaring of (1 + x^7 + x^9); seven factors give its inverse mod x^128+1.
  always_comb begin
    v_step = v;
    case (iter)
      3'd0: v_step = v ^ rotl(v, 7)   ^ rotl(v, 9);
      3'd1: v_step = v ^ rotl(v, 14)  ^ rotl(v, 18);
      3'd2: v_step = v ^ rotl(v, 28)  ^ rotl(v, 36);
      3'd3: v_step = v ^ rotl(v, 56)  ^ rotl(v, 72);
      3'd4: v_step = v ^ rotl(v, 112) ^ rotl(v, 16);
      3'd5: v_step = v ^ rotl(v, 96)  ^ rotl(v, 32);
      3'd6: v_step = v ^ rotl(v, 64)  ^ rotl(v, 64);
      default: v_step = v;
    endcase
  end

  always_comb begin
    t = '0;
    for (int i = 0; i < 128; i++) begin
      t[7'((15 * i) % 128)] = work[i];
    end
  end

  assign l = rotl(v, 127);
  assign h = t ^ (rotl(l, 12) & l) ^ rotl(l, 1);

  always_comb begin
    state_nx = state;
    work_nx  = work;
    v_nx     = v;
    iter_nx  = iter;
    steps_nx = steps;
    case (state)
      IDLE: begin
        if (in_valid) begin
          work_nx  = key_in;
          steps_nx = n_steps;
          v_nx     = key_in[255:128];
          iter_nx  = 3'd0;
          state_nx = (n_steps == 6'd0) ? DONE : LIN;
        end
      end
      LIN: begin
        v_nx    = v_step;
        iter_nx = iter + 3'd1;
        if (iter == 3'd6) begin
          iter_nx  = 3'd0;
          state_nx = FIN;
        end
      end
      FIN: begin
        work_nx  = {h, l};
        steps_nx = steps - 6'd1;
        v_nx     = h;
        iter_nx  = 3'd0;
        state_nx = (steps == 6'd1) ? DONE : LIN;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      v     <= '0;
      iter  <= '0;
      steps <= '0;
    end else begin
      state <= state_nx;
      work  <= work_nx;
      v     <= v_nx;
      iter  <= iter_nx;
      steps <= steps_nx;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign key_out   = out_valid ? work : '0;

endmodule

// File: tb/tb_sonic_inv_key_schedule_128x256.sv
// Bench for the inverse key schedule: a forward-step golden model produces keys
// whose backward image is known, plus fixed vectors and handshake corner cases.
module tb_sonic_inv_key_schedule_128x256;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] key_in;
  logic [5:0]   n_steps;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] key_out;

  int compared   = 0;
  int mismatched = 0;

  sonic_inv_key_schedule_128x256 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key_in    (key_in),
    .n_steps   (n_steps),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .key_out   (key_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] key;
    logic [5:0]   n;
    logic [255:0] exp;
    int           lat;
  } vec_t;

  function automatic logic [127:0] rl(input logic [127:0] x, input int k);
    int m;
    m = k % 128;
    if (m == 0) return x;
    return (x << m) | (x >> (128 - m));
  endfunction

  // Forward step from {H, L} to {Y, X}.
  function automatic logic [255:0] fwd(input logic [255:0] s);
    logic [127:0] hh, ll, tt, hi, lo;
    hh = s[255:128];
    ll = s[127:0];
    tt = hh ^ (rl(ll, 12) & ll) ^ rl(ll, 1);
    hi = rl(ll, 1) ^ rl(ll, 8) ^ rl(ll, 10);
    lo = '0;
    for (int i = 0; i < 128; i++) lo[i] = tt[(15 * i) % 128];
    return {hi, lo};
  endfunction

  function automatic logic [255:0] fwdN(input logic [255:0] s, input int k);
    logic [255:0] r;
    r = s;
    for (int i = 0; i < k; i++) r = fwd(r);
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following the accept edge.
  task automatic applyStimulus(input logic [255:0] k, input logic [5:0] n);
    in_valid = 1'b1;
    key_in   = k;
    n_steps  = n;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    key_in   = rnd256();
    n_steps  = 6'($urandom());
  endtask

  task automatic runRequest(input logic [255:0] k, input logic [5:0] n, input int hold,
                            output logic [255:0] res, output int lat);
    logic zeroOk;
    logic stableOk;
    checkOutput("in_ready_before_accept", 256'(in_ready), 256'd1);
    applyStimulus(k, n);
    lat    = 1;
    zeroOk = 1'b1;
    while (!out_valid && lat < 700) begin
      if (key_out !== '0) zeroOk = 1'b0;
      @(negedge clk);
      lat++;
    end
    checkOutput("key_out_zero_while_busy", 256'(zeroOk), 256'd1);
    res      = key_out;
    stableOk = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (key_out !== res || out_valid !== 1'b1 || in_ready !== 1'b0) stableOk = 1'b0;
    end
    if (hold > 0) checkOutput("hold_stable", 256'(stableOk), 256'd1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t         vecs[10];
  vec_t         b2b[6];
  logic [255:0] res;
  int           lat;
  logic [255:0] kk;
  int           kn;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    key_in    = '0;
    n_steps   = '0;
    out_ready = 1'b0;

    vecs[0] = '{256'h0, 6'd1, 256'h0, 9};
    vecs[1] = '{256'h1, 6'd1, {128'h1, 128'h0}, 9};
    vecs[2] = '{256'h2, 6'd1, {128'h8000, 128'h0}, 9};
    vecs[3].exp = rnd256(); vecs[3].n = 6'd0;  vecs[3].key = vecs[3].exp; vecs[3].lat = 1;
    vecs[4].exp = rnd256(); vecs[4].n = 6'd63;
    vecs[5].exp = rnd256(); vecs[5].n = 6'd2;
    for (int i = 6; i < 10; i++) begin
      vecs[i].exp = rnd256();
      vecs[i].n   = 6'($urandom_range(1, 63));
    end
    for (int i = 4; i < 10; i++) begin
      vecs[i].key = fwdN(vecs[i].exp, int'(vecs[i].n));
      vecs[i].lat = 1 + 8 * int'(vecs[i].n);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 256'(in_ready), 256'd1);
    checkOutput("reset_out_valid", 256'(out_valid), 256'd0);
    checkOutput("reset_key_out", key_out, 256'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      runRequest(vecs[i].key, vecs[i].n, 0, res, lat);
      checkOutput($sformatf("vec%0d_key", i), res, vecs[i].exp);
      checkOutput($sformatf("vec%0d_latency", i), 256'(lat), 256'(vecs[i].lat));
    end

    for (int i = 0; i < 6; i++) begin
      kk = rnd256();
      kn = int'($urandom_range(0, 5));
      runRequest(fwdN(kk, kn), 6'(kn), int'($urandom_range(0, 3)), res, lat);
      checkOutput($sformatf("rand%0d_key", i), res, kk);
      checkOutput($sformatf("rand%0d_latency", i), 256'(lat), 256'(1 + 8 * kn));
    end

    // Zero-step request held off by the consumer, with in_valid asserted meanwhile.
    begin
      logic okHold;
      kk = rnd256();
      applyStimulus(kk, 6'd0);
      checkOutput("n0_out_valid_after_1", 256'(out_valid), 256'd1);
      checkOutput("n0_key", key_out, kk);
      in_valid = 1'b1;
      key_in   = rnd256();
      okHold   = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (key_out !== kk || in_ready !== 1'b0 || out_valid !== 1'b1) okHold = 1'b0;
      end
      checkOutput("n0_hold_5_cycles", 256'(okHold), 256'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("n0_release_idle", 256'(in_ready), 256'd1);
      checkOutput("n0_release_no_valid", 256'(out_valid), 256'd0);
    end

    // Reset during the third LIN iteration aborts the request.
    begin
      logic noValid;
      kk = rnd256();
      applyStimulus(fwdN(kk, 2), 6'd2);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_in_ready", 256'(in_ready), 256'd1);
      checkOutput("abort_out_valid", 256'(out_valid), 256'd0);
      checkOutput("abort_key_out", key_out, 256'd0);
      noValid = 1'b1;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (out_valid !== 1'b0 || in_ready !== 1'b1) noValid = 1'b0;
      end
      checkOutput("abort_no_late_result", 256'(noValid), 256'd1);
      runRequest(fwdN(kk, 3), 6'd3, 1, res, lat);
      checkOutput("after_abort_key", res, kk);
      checkOutput("after_abort_latency", 256'(lat), 256'd25);
    end

    // Back-to-back with in_valid held high and the consumer always ready.
    begin
      int   p, got, cycles;
      logic gapOk, prevValid, acceptNow;
      for (int i = 0; i < 6; i++) begin
        b2b[i].exp = rnd256();
        b2b[i].n   = 6'(i % 3);
        b2b[i].key = fwdN(b2b[i].exp, i % 3);
        b2b[i].lat = 0;
      end
      p = 0; got = 0; cycles = 0; gapOk = 1'b1; prevValid = 1'b0;
      out_ready = 1'b1;
      while (got < 6 && cycles < 400) begin
        if (prevValid && (in_ready !== 1'b1 || out_valid !== 1'b0)) gapOk = 1'b0;
        if (out_valid) begin
          checkOutput($sformatf("b2b%0d_key", got), key_out, b2b[got].exp);
          got++;
        end
        prevValid = out_valid;
        in_valid  = (p < 6);
        if (p < 6) begin
          key_in  = b2b[p].key;
          n_steps = b2b[p].n;
        end
        acceptNow = in_ready && (p < 6);
        @(posedge clk);
        if (acceptNow) p++;
        @(negedge clk);
        cycles++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checkOutput("b2b_results", 256'(got), 256'd6);
      checkOutput("b2b_accepts", 256'(p), 256'd6);
      checkOutput("b2b_idle_gap", 256'(gapOk), 256'd1);
      repeat (3) @(negedge clk);
      checkOutput("b2b_no_extra", 256'(out_valid), 256'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sonic_inv_key_schedule_128x256.md
SONIC_INV_KEY_SCHEDULE_128X256 -- requirements
Module: sonic_inv_key_schedule_128x256

Interface
Parameters: none.
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1; a request is presented.
REQ-004 SHALL have port in_ready, output, 1; block can accept a request.
REQ-005 SHALL have port key_in, input, 256; round key K_r = {Y, X}, where Y = key_in[255:128] and X = key_in[127:0].
REQ-006 SHALL have port n_steps, input, 6; number of backward schedule steps, 0..63.
REQ-007 SHALL have port out_valid, output, 1; key_out holds a result.
REQ-008 SHALL have port out_ready, input, 1; consumer accepts the result.
REQ-009 SHALL have port key_out, output, 256; key after n_steps backward steps.

Function
Notation: rotl(v,k) = v rotated left by k bits, 128-bit; Y = upper half, X = lower half.
REQ-010 SHALL define one backward step S^-1 as the exact inverse of the forward step.
- Forward step, for reference: hi' = rotl(L,1)^rotl(L,8)^rotl(L,10); lo'[i] = t[(15*i)%128], with t = H ^ (rotl(L,12)&L) ^ rotl(L,1).
REQ-011 SHALL recover t from X as t[(15*i)%128] = X[i] for i = 0..127 (pure wiring).
REQ-012 SHALL recover L from Y iteratively.
- v0 = Y.
- Seven iterations j = 0..6: v = v ^ rotl(v,a_j) ^ rotl(v,b_j).
- (a_j,b_j) = (7,9), (14,18), (28,36), (56,72), (112,16), (96,32), (64,64).
- L = rotl(v,127).
- Iteration 6 is the identity; it SHALL still occupy its cycle.
REQ-013 SHALL compute H = t ^ (rotl(L,12)&L) ^ rotl(L,1); the step result is {H, L}.
REQ-014 SHALL implement FSM states IDLE, LIN, FIN, DONE:
- IDLE: in_ready=1. in_valid & in_ready captures key_in and n_steps. Go to DONE if n_steps==0, else LIN with iter=0.
- LIN: one iteration per cycle; after iter==6 go to FIN.
- FIN: one cycle; the working register becomes {H,L} and the step counter decrements. Go to LIN if steps remain, else DONE.
- DONE: out_valid=1, key_out = working register. On out_ready go to IDLE.
REQ-015 SHALL give latency from the accept edge to the first out_valid=1 cycle of 1 + 8*n_steps cycles (n_steps=0 -> 1 cycle, key_out = key_in).
REQ-016 SHALL hold in_ready=0 in LIN, FIN and DONE; in_valid in those states SHALL be ignored and not queued.
REQ-017 SHALL hold key_out stable while out_valid=1 and out_ready=0.
REQ-018 SHALL drive key_out to 0 whenever out_valid=0.
REQ-019 SHALL make same-cycle out_ready and in_valid in DONE take effect as DONE->IDLE only; the new request is accepted no earlier than the following cycle.
REQ-020 SHALL ignore changes to key_in and n_steps after the accept edge.

Reset
REQ-021 SHALL, with rst=1 at a clock edge, enter IDLE and zero the working register, counters and iteration index. After that edge in_ready=1, out_valid=0 and key_out=0.
REQ-022 SHALL abort any in-flight computation on reset mid-operation, produce no out_valid for it, and take priority over all other inputs.

Verification
REQ-023 SHALL cover key_in=0, n_steps=1 -> out_valid 9 cycles after accept, key_out=0.
REQ-024 SHALL cover key_in=256'h1, n_steps=1 -> key_out={128'h1,128'h0}. Also key_in=256'h2, n_steps=1 -> key_out={128'h8000,128'h0}.
REQ-025 SHALL cover random K, n_steps=k in 1..63, with key_in = forward^k(K) from a golden model -> key_out=K, with latency 1+8k.
REQ-026 SHALL cover n_steps=0, key_in=random -> key_out=key_in one cycle after accept, with out_ready held low 5 cycles -> key_out stable and in_ready=0 throughout.
REQ-027 SHALL cover rst asserted in LIN during the third iteration -> next cycle in_ready=1, out_valid=0, key_out=0. A fresh request then completes correctly.
REQ-028 SHALL cover in_valid held high continuously with out_ready=1 -> back-to-back results, one idle cycle between DONE and the next accept, and no request lost or duplicated.
